// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two valid/ready requesters
module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0][WIDTH-1:0] req_a_i,
  input  logic [1:0][WIDTH-1:0] req_b_i,
  input  logic [1:0][2:0]       req_op_i,
  output logic [1:0]            rsp_valid_o,
  input  logic [1:0]            rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_result_o,
  output logic                  rsp_zero_o,
  output logic [WIDTH-1:0]      alu_srca_o,
  output logic [WIDTH-1:0]      alu_srcb_o,
  output logic [2:0]            alu_control_o,
  input  logic [WIDTH-1:0]      alu_result_i,
  input  logic                  alu_zero_i
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q;
  logic             gnt_q, prio_q, gnt_d, exec;
  logic [WIDTH-1:0] op_a_q, op_b_q, rsp_result_q;
  logic [2:0]       op_c_q;
  logic             rsp_zero_q;
  // Arbitration and handshake outputs; reset masks everything so nothing leaks during it
  always_comb begin
    gnt_d         = &req_valid_i ? prio_q : req_valid_i[1];
    req_ready_o   = (!reset_i && state_q == IDLE && |req_valid_i) ? {gnt_d, ~gnt_d} : 2'b00;
    rsp_valid_o   = (!reset_i && state_q == RESP) ? {gnt_q, ~gnt_q} : 2'b00;
    exec          = !reset_i && state_q == EXEC;
    alu_srca_o    = exec ? op_a_q : '0;
    alu_srcb_o    = exec ? op_b_q : '0;
    alu_control_o = exec ? op_c_q : 3'b000;
    rsp_result_o  = rsp_result_q;
    rsp_zero_o    = rsp_zero_q;
  end
  // Accept -> drive ALU for one cycle -> hold response; priority flips only on completion
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      prio_q       <= PRIO_RESET;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_c_q       <= 3'b000;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|req_valid_i) begin
          gnt_q   <= gnt_d;
          op_a_q  <= req_a_i[gnt_d];
          op_b_q  <= req_b_i[gnt_d];
          op_c_q  <= req_op_i[gnt_d];
          state_q <= EXEC;
        end
        EXEC: begin
          rsp_result_q <= alu_result_i;
          rsp_zero_q   <= alu_zero_i;
          state_q      <= RESP;
        end
        RESP: if (rsp_ready_i[gnt_q]) begin
          prio_q  <= ~gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, backpressure and reset behaviour
module tb_alu_arbiter;
  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][31:0] req_a, req_b;
  logic [1:0][2:0]  req_op;
  logic [31:0]      rsp_result, alu_srca, alu_srcb, alu_result;
  logic             rsp_zero, alu_zero;
  logic [2:0]       alu_control;
  int               tests = 0, fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .PRIO_RESET(1'b0)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero),
    .alu_srca_o(alu_srca), .alu_srcb_o(alu_srcb), .alu_control_o(alu_control),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero)
  );

  always_comb begin
    case (alu_control)
      3'b000:  alu_result = alu_srca + alu_srcb;
      3'b001:  alu_result = alu_srca - alu_srcb;
      3'b010:  alu_result = alu_srca & alu_srcb;
      3'b011:  alu_result = alu_srca | alu_srcb;
      3'b101:  alu_result = {31'd0, $signed(alu_srca) < $signed(alu_srcb)};
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid = 2'b11; rsp_ready = 2'($urandom);
      req_a = {$urandom(), $urandom()}; req_b = {$urandom(), $urandom()}; req_op = 6'($urandom);
      tick; #1;
      tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
      tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
      tests++; if ({rsp_result, rsp_zero} !== 33'd0) begin fails++; $display("FAIL reset_rsp got %h/%b exp 0/0", rsp_result, rsp_zero); end
      tests++; if ({alu_srca, alu_srcb, alu_control} !== 67'd0) begin fails++; $display("FAIL reset_alu_drive got %h %h %b exp 0", alu_srca, alu_srcb, alu_control); end
    end
    reset = 1'b0; req_valid = 2'b11; #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL reset_first_grant got %b exp 01", req_ready); end
    tick; req_valid = 2'b00; reset = 1'b1;
    tick; reset = 1'b0; rsp_ready = 2'b00;
  endtask

  task automatic test_single_add;
    req_valid = 2'b01; req_a[0] = 32'd7; req_b[0] = 32'd5; req_op[0] = 3'b000; #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL add_ready got %b exp 01", req_ready); end
    tick; req_valid = 2'b00; #1;
    tests++; if ({alu_srca, alu_srcb, alu_control} !== {32'd7, 32'd5, 3'b000}) begin fails++; $display("FAIL add_alu_drive got %h %h %b exp 7 5 000", alu_srca, alu_srcb, alu_control); end
    tests++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin fails++; $display("FAIL add_exec_hs got %b/%b exp 00/00", rsp_valid, req_ready); end
    tick; rsp_ready = 2'b01; #1;
    tests++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL add_rsp_valid got %b exp 01", rsp_valid); end
    tests++; if (rsp_result !== 32'd12 || rsp_zero !== 1'b0) begin fails++; $display("FAIL add_result got %h/%b exp c/0", rsp_result, rsp_zero); end
    tests++; if ({alu_srca, alu_control} !== 35'd0) begin fails++; $display("FAIL add_alu_idle got %h %b exp 0", alu_srca, alu_control); end
    tick; rsp_ready = 2'b00; #1;
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL add_done got %b exp 00", rsp_valid); end
  endtask

  task automatic test_round_robin;
    reset = 1'b1; tick; reset = 1'b0;
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_a[0] = 32'd5; req_b[0] = 32'd5; req_op[0] = 3'b001;
    req_a[1] = 32'hFFFF_FFFF; req_b[1] = 32'd1; req_op[1] = 3'b101;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin fails++; $display("FAIL rr_grant%0d got %b", k, req_ready); end
      tick; #1;
      tests++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin fails++; $display("FAIL rr_exec%0d got %b/%b exp 00/00", k, req_ready, rsp_valid); end
      tick; #1;
      tests++; if (rsp_valid !== ((k % 2 == 0) ? 2'b01 : 2'b10) || req_ready !== 2'b00) begin fails++; $display("FAIL rr_rsp%0d got %b/%b", k, rsp_valid, req_ready); end
      tests++; if ({rsp_result, rsp_zero} !== ((k % 2 == 0) ? {32'd0, 1'b1} : {32'd1, 1'b0})) begin fails++; $display("FAIL rr_result%0d got %h/%b", k, rsp_result, rsp_zero); end
      tick;
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure;
    req_valid = 2'b10; req_a[1] = 32'hF0; req_b[1] = 32'h0F; req_op[1] = 3'b011; #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_ready got %b exp 10", req_ready); end
    tick; req_valid = 2'b01; req_a[0] = 32'd1; req_b[0] = 32'd2; req_op[0] = 3'b000;
    tick;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (rsp_valid !== 2'b10 || rsp_result !== 32'hFF || rsp_zero !== 1'b0) begin fails++; $display("FAIL bp_hold%0d got %b %h %b exp 10 ff 0", i, rsp_valid, rsp_result, rsp_zero); end
      tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_noready%0d got %b exp 00", i, req_ready); end
      tick;
    end
    rsp_ready = 2'b10; #1;
    tests++; if (rsp_valid !== 2'b10 || req_ready !== 2'b00) begin fails++; $display("FAIL bp_release got %b/%b exp 10/00", rsp_valid, req_ready); end
    tick; rsp_ready = 2'b00; #1;
    tests++; if (req_ready !== 2'b01 || rsp_valid !== 2'b00) begin fails++; $display("FAIL bp_next_ready got %b/%b exp 01/00", req_ready, rsp_valid); end
    tick; req_valid = 2'b00; tick; rsp_ready = 2'b01; #1;
    tests++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd3) begin fails++; $display("FAIL bp_next_rsp got %b %h exp 01 3", rsp_valid, rsp_result); end
    tick; rsp_ready = 2'b00;
  endtask

  task automatic test_undecoded;
    req_valid = 2'b01; req_a[0] = 32'hFFFF_FFFF; req_b[0] = 32'hFFFF_FFFF; req_op[0] = 3'b110; #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL undec_ready got %b exp 01", req_ready); end
    tick; req_valid = 2'b00; #1;
    tests++; if (alu_control !== 3'b110 || alu_srca !== 32'hFFFF_FFFF) begin fails++; $display("FAIL undec_drive got %b %h exp 110 ffffffff", alu_control, alu_srca); end
    tick; rsp_ready = 2'b01; #1;
    tests++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin fails++; $display("FAIL undec_rsp got %b %h %b exp 01 0 1", rsp_valid, rsp_result, rsp_zero); end
    tick; rsp_ready = 2'b00; #1;
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL undec_done got %b exp 00", rsp_valid); end
  endtask

  task automatic test_reset_midflight;
    rsp_ready = 2'b11;
    req_valid = 2'b10; req_a[1] = 32'd3; req_b[1] = 32'd4; req_op[1] = 3'b000; #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL rmf_ready1 got %b exp 10", req_ready); end
    tick; req_valid = 2'b00; reset = 1'b1; #1;
    tests++; if (rsp_valid !== 2'b00 || alu_srca !== 32'd0) begin fails++; $display("FAIL rmf_exec got %b %h exp 00 0", rsp_valid, alu_srca); end
    tick; reset = 1'b0; #1;
    tests++; if (rsp_valid !== 2'b00 || {alu_srca, alu_control} !== 35'd0) begin fails++; $display("FAIL rmf_after_exec got %b %h %b", rsp_valid, alu_srca, alu_control); end
    tick; #1;
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL rmf_idle got %b exp 00", rsp_valid); end
    req_valid = 2'b10; #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL rmf_ready2 got %b exp 10", req_ready); end
    tick; req_valid = 2'b00;
    tick; reset = 1'b1; #1;
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL rmf_resp got %b exp 00", rsp_valid); end
    tick; reset = 1'b0; #1;
    tests++; if (rsp_valid !== 2'b00 || rsp_result !== 32'd0) begin fails++; $display("FAIL rmf_after_resp got %b %h exp 00 0", rsp_valid, rsp_result); end
    req_valid = 2'b01; req_a[0] = 32'd10; req_b[0] = 32'd3; req_op[0] = 3'b001; #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL rmf_ready3 got %b exp 01", req_ready); end
    tick; req_valid = 2'b00; tick; #1;
    tests++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd7 || rsp_zero !== 1'b0) begin fails++; $display("FAIL rmf_recover got %b %h %b exp 01 7 0", rsp_valid, rsp_result, rsp_zero); end
    tick; rsp_ready = 2'b00; #1;
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL rmf_done got %b exp 00", rsp_valid); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a = '0; req_b = '0; req_op = '0;
    test_reset;
    test_single_add;
    test_round_robin;
    test_backpressure;
    test_undecoded;
    test_reset_midflight;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
